// File: rtl/cntr_ctrl.sv
// BCD 00..99 counter with command-driven IDLE/RUN/PAUSE/DONE control and a clock prescaler.
// Optional down-counting (dir port) is enabled by defining CNTR_CTRL_DOWN_EN.
module cntr_ctrl #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    input  logic       auto_reload,
`ifdef CNTR_CTRL_DOWN_EN
    input  logic       dir,
`endif
    output logic [7:0] cntr_99,
    output logic [1:0] state,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        C_NOP   = 2'b00,
        C_START = 2'b01,
        C_STOP  = 2'b10,
        C_CLEAR = 2'b11
    } cmd_t;

    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

    state_t     st, st_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] ps, ps_n;
    logic       done_n, rdy_n;
    logic       acc, tick, down;
    logic [7:0] term_val, reload_val;

`ifdef CNTR_CTRL_DOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        bcd_inc = (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        bcd_dec = (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign acc        = cmd_valid & cmd_ready;
    assign tick       = (st == S_RUN) && (ps == PS_LAST);
    assign term_val   = down ? 8'h00 : 8'h99;
    assign reload_val = down ? 8'h99 : 8'h00;

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        ps_n   = ps;
        done_n = 1'b0;
        rdy_n  = ~acc;

        if (st == S_RUN) ps_n = tick ? 8'd0 : ps + 8'd1;

        if (tick) begin
            if (cnt == term_val) begin
                done_n = 1'b1;
                if (auto_reload) cnt_n = reload_val;
                else             st_n  = S_DONE;
            end else begin
                cnt_n = down ? bcd_dec(cnt) : bcd_inc(cnt);
            end
        end

        // Accepted STOP/CLEAR override the tick results computed above.
        if (acc) begin
            unique case (cmd_t'(cmd))
                C_START: begin
                    if (st != S_RUN) begin
                        st_n = S_RUN;
                        ps_n = '0;
                        if (st == S_DONE) cnt_n = reload_val;
                    end
                end
                C_STOP: begin
                    if (st == S_RUN) begin
                        st_n   = S_PAUSE;
                        cnt_n  = cnt;
                        ps_n   = ps;
                        done_n = 1'b0;
                    end
                end
                C_CLEAR: begin
                    st_n   = S_IDLE;
                    cnt_n  = '0;
                    ps_n   = '0;
                    done_n = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st        <= S_IDLE;
            cnt       <= '0;
            ps        <= '0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            ps        <= ps_n;
            done      <= done_n;
            cmd_ready <= rdy_n;
        end
    end

    assign cntr_99 = cnt;
    assign state   = st;
    assign running = (st == S_RUN);

endmodule

// File: tb/tb_cntr_ctrl.sv
// Self-checking bench for cntr_ctrl: directed scenarios plus randomized commands
// compared against a decimal-integer reference model.
module tb_cntr_ctrl;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready;
    logic       auto_reload = 1'b0;
    logic [7:0] cntr_99;
    logic [1:0] state;
    logic       running;
    logic       done;
`ifdef CNTR_CTRL_DOWN_EN
    logic       dir = 1'b0;
`endif

    cntr_ctrl #(.PRESCALE(P)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .auto_reload(auto_reload),
`ifdef CNTR_CTRL_DOWN_EN
        .dir(dir),
`endif
        .cntr_99(cntr_99), .state(state), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: count as a plain integer 0..99, phase = cycles into the current tick period.
    int m_st = 0;
    int m_val = 0;
    int m_ph = 0;
    bit m_rdy = 1'b1;
    bit m_done = 1'b0;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    // Advance one clock edge: model consumes the inputs currently applied, DUT sees the same edge.
    task automatic step();
        bit acc, tk, dn;
        int nst, nval, nph;
        bit ndone;
        dn = 1'b0;
`ifdef CNTR_CTRL_DOWN_EN
        dn = dir;
`endif
        acc = cmd_valid && m_rdy;
        tk = (m_st == 1) && (m_ph == P - 1);
        nst = m_st; nval = m_val; nph = m_ph; ndone = 1'b0;
        if (m_st == 1) nph = (m_ph + 1) % P;
        if (tk) begin
            if (m_val == (dn ? 0 : 99)) begin
                ndone = 1'b1;
                if (auto_reload) nval = dn ? 99 : 0;
                else nst = 3;
            end else begin
                nval = dn ? m_val - 1 : m_val + 1;
            end
        end
        if (acc) begin
            if (cmd == 2'b01 && m_st != 1) begin
                nst = 1; nph = 0;
                if (m_st == 3) nval = dn ? 99 : 0;
            end else if (cmd == 2'b10 && m_st == 1) begin
                nst = 2; nval = m_val; nph = m_ph; ndone = 1'b0;
            end else if (cmd == 2'b11) begin
                nst = 0; nval = 0; nph = 0; ndone = 1'b0;
            end
        end
        if (!reset_n) begin
            nst = 0; nval = 0; nph = 0; ndone = 1'b0; acc = 1'b0;
        end
        @(posedge clk);
        #1;
        m_st = nst; m_val = nval; m_ph = nph; m_done = ndone; m_rdy = !acc;
    endtask

    task automatic issue(input logic [1:0] c);
        if (!m_rdy) step();
        cmd_valid = 1'b1;
        cmd = c;
        step();
        cmd_valid = 1'b0;
        cmd = 2'b00;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd_valid = 1'b1;
        cmd = 2'b01;
        step();
        step();
        cmd_valid = 1'b0;
        cmd = 2'b00;
        n_checks++; if (cntr_99 !== 8'h00) $display("FAIL rst_cnt: got %h want 00", cntr_99); else n_pass++;
        n_checks++; if (state !== 2'b00) $display("FAIL rst_state: got %b want 00", state); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_checks++; if (running !== 1'b0) $display("FAIL rst_running: got %b want 0", running); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", cmd_ready); else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_counting();
        auto_reload = 1'b0;
        issue(2'b11);
        issue(2'b01);
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL rdy_low: got %b want 0", cmd_ready); else n_pass++;
        n_checks++; if (running !== 1'b1) $display("FAIL run_after_start: got %b want 1", running); else n_pass++;
        step();
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rdy_back: got %b want 1", cmd_ready); else n_pass++;
        step(); step();
        n_checks++; if (cntr_99 !== 8'h00) $display("FAIL cnt_e3: got %h want 00", cntr_99); else n_pass++;
        step();
        n_checks++; if (cntr_99 !== 8'h01) $display("FAIL cnt_e4: got %h want 01", cntr_99); else n_pass++;
        repeat (32) step();
        n_checks++; if (cntr_99 !== 8'h09) $display("FAIL cnt_e36: got %h want 09", cntr_99); else n_pass++;
        repeat (4) step();
        n_checks++; if (cntr_99 !== 8'h10) $display("FAIL cnt_e40: got %h want 10", cntr_99); else n_pass++;
    endtask

    task automatic test_oneshot();
        auto_reload = 1'b0;
        issue(2'b11);
        issue(2'b01);
        repeat (396) step();
        n_checks++; if (cntr_99 !== 8'h99 || state !== 2'b01) $display("FAIL os_e396: got %h/%b want 99/01", cntr_99, state); else n_pass++;
        repeat (3) step();
        n_checks++; if (done !== 1'b0) $display("FAIL os_nodone_e399: got %b want 0", done); else n_pass++;
        step();
        n_checks++; if (done !== 1'b1 || state !== 2'b11 || running !== 1'b0) $display("FAIL os_e400: got done=%b state=%b run=%b want 1/11/0", done, state, running); else n_pass++;
        step();
        n_checks++; if (done !== 1'b0 || cntr_99 !== 8'h99) $display("FAIL os_hold: got done=%b cnt=%h want 0/99", done, cntr_99); else n_pass++;
        issue(2'b01);
        n_checks++; if (cntr_99 !== 8'h00 || state !== 2'b01) $display("FAIL os_restart: got %h/%b want 00/01", cntr_99, state); else n_pass++;
    endtask

    task automatic test_auto_reload();
        auto_reload = 1'b1;
        issue(2'b11);
        issue(2'b01);
        repeat (400) step();
        n_checks++; if (cntr_99 !== 8'h00 || done !== 1'b1 || state !== 2'b01) $display("FAIL ar_e400: got %h done=%b state=%b want 00/1/01", cntr_99, done, state); else n_pass++;
        repeat (4) step();
        n_checks++; if (cntr_99 !== 8'h01 || done !== 1'b0) $display("FAIL ar_e404: got %h done=%b want 01/0", cntr_99, done); else n_pass++;
        auto_reload = 1'b0;
    endtask

    task automatic test_stop_on_tick();
        issue(2'b11);
        issue(2'b01);
        repeat (23) step();
        n_checks++; if (cntr_99 !== 8'h05) $display("FAIL st_pre: got %h want 05", cntr_99); else n_pass++;
        issue(2'b10);
        n_checks++; if (cntr_99 !== 8'h05 || state !== 2'b10 || done !== 1'b0) $display("FAIL st_stop: got %h/%b done=%b want 05/10/0", cntr_99, state, done); else n_pass++;
        repeat (8) step();
        n_checks++; if (cntr_99 !== 8'h05) $display("FAIL st_hold: got %h want 05", cntr_99); else n_pass++;
        issue(2'b01);
        repeat (3) step();
        n_checks++; if (cntr_99 !== 8'h05) $display("FAIL st_res3: got %h want 05", cntr_99); else n_pass++;
        step();
        n_checks++; if (cntr_99 !== 8'h06 || state !== 2'b01) $display("FAIL st_res4: got %h/%b want 06/01", cntr_99, state); else n_pass++;
    endtask

    task automatic test_clear();
        issue(2'b11);
        issue(2'b01);
        repeat (169) step();
        n_checks++; if (cntr_99 !== 8'h42) $display("FAIL clr_pre: got %h want 42", cntr_99); else n_pass++;
        issue(2'b11);
        n_checks++; if (cntr_99 !== 8'h00 || state !== 2'b00 || running !== 1'b0) $display("FAIL clr: got %h/%b run=%b want 00/00/0", cntr_99, state, running); else n_pass++;
`ifdef CNTR_CTRL_DOWN_EN
        issue(2'b01);
        repeat (40) step();
        dir = 1'b1;
        repeat (4) step();
        n_checks++; if (cntr_99 !== 8'h09) $display("FAIL down: got %h want 09", cntr_99); else n_pass++;
        dir = 1'b0;
        issue(2'b11);
`endif
    endtask

    // Random commands; every cycle the full output vector is compared with the model.
    task automatic test_random(input int cycles, input int cmd_rate);
        logic [12:0] got, exp;
        int r;
        for (int i = 0; i < cycles; i++) begin
            reset_n = ($urandom_range(0, 499) != 0);
            cmd_valid = ($urandom_range(0, cmd_rate - 1) == 0);
            r = $urandom_range(0, 9);
            cmd = (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : (r < 8) ? 2'b11 : 2'b00;
            if ($urandom_range(0, 7) == 0) auto_reload = $urandom_range(0, 1) != 0;
            step();
            got = {cntr_99, state, running, done, cmd_ready};
            exp = {to_bcd(m_val), 2'(m_st), (m_st == 1), m_done, m_rdy};
            n_checks++;
            if (got !== exp) $display("FAIL rand_cyc%0d: got cnt=%h st=%b run=%b done=%b rdy=%b want cnt=%h st=%b run=%b done=%b rdy=%b",
                                      i, got[12:5], got[4:3], got[2], got[1], got[0], exp[12:5], exp[4:3], exp[2], exp[1], exp[0]);
            else n_pass++;
        end
        reset_n = 1'b1;
        cmd_valid = 1'b0;
        cmd = 2'b00;
    endtask

    initial begin
        test_reset();
        test_counting();
        test_oneshot();
        test_auto_reload();
        test_stop_on_tick();
        test_clear();
        test_random(3000, 6);
        test_random(6000, 300);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
